cpt_seq: RTL and testbench

Parametrised sequential magnitude comparator; the multi-cycle, wide-operand successor to the team's 4-bit combinational comparator. It latches two WIDTH-bit operands on a start pulse and compares them MSB-first, STEP bits per cycle, stopping at the first differing digit. It then reports GT/EQ/LT with a one-cycle done pulse. Unsigned and two's-complement modes are supported. It sits between a register-file/datapath source and any control FSM that needs ordering decisions on operands too wide for a single-cycle compare.

---
 rtl/cpt_seq.sv | 119 +++++++++++
 tb/tb_cpt_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpt_seq.sv
// Sequential magnitude comparator: latches two WIDTH-bit operands and compares them
// MSB-first, STEP bits per cycle, stopping at the first differing digit.
module cpt_seq #(
    parameter int WIDTH = 16,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             GT,
    output logic             EQ,
    output logic             LT,
    output logic             Y
);
    localparam int N  = WIDTH / STEP;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IW-1:0]    idx_r;
    logic [STEP-1:0]  digit_a_s;
    logic [STEP-1:0]  digit_b_s;
    logic             differ_s;
    logic             last_s;
    logic             accept_s;
    logic             finish_s;

    // Offset-binary mapping: flipping the sign bit makes signed order match unsigned order.
    function automatic logic [WIDTH-1:0] to_offset(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] mask;
        mask = '0;
        mask[WIDTH-1] = sgn;
        return v ^ mask;
    endfunction

    // Current digit sits in the top STEP bits because the operands shift left each RUN cycle.
    always_comb begin
        digit_a_s = a_r[WIDTH-1 -: STEP];
        digit_b_s = b_r[WIDTH-1 -: STEP];
        differ_s  = (digit_a_s != digit_b_s);
        last_s    = (idx_r == LAST_IDX);
        accept_s  = start && (state_r != RUN);
        finish_s  = (state_r == RUN) && (differ_s || last_s);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (differ_s || last_s) state_s = DONE;
                else                    state_s = RUN;
            end
            DONE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Operand shifters, digit index, status flags and the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            idx_r <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            GT    <= 1'b0;
            EQ    <= 1'b0;
            LT    <= 1'b0;
            Y     <= 1'b0;
        end else begin
            busy <= (state_s == RUN);
            done <= (state_s == DONE);
            if (accept_s) begin
                a_r   <= to_offset(A, signed_mode);
                b_r   <= to_offset(B, signed_mode);
                idx_r <= '0;
            end else if (state_r == RUN) begin
                a_r   <= a_r << STEP;
                b_r   <= b_r << STEP;
                idx_r <= idx_r + IW'(1);
            end
            // Result changes only on the edge entering DONE; it holds across later starts.
            if (finish_s) begin
                GT <= (digit_a_s > digit_b_s);
                EQ <= !differ_s;
                LT <= (digit_a_s < digit_b_s);
                Y  <= (digit_a_s > digit_b_s);
            end
        end
    end
endmodule

// File: tb/tb_cpt_seq.sv
// Bench for cpt_seq: directed cases on a 16/4 instance plus a random sweep over
// nine WIDTH/STEP configurations, all checked cycle by cycle against a golden model.
module tb_cpt_seq;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        sm;
    logic        busy, done, gt, eq, lt, y;

    int n_total = 0;
    int n_pass  = 0;
    logic chk_on = 1'b0;
    logic sw_on  = 1'b0;
    logic sw_go  = 1'b0;

    logic [5:0] sw_act [9];
    logic [5:0] sw_exp [9];
    logic [8:0] sw_fin;

    cpt_seq #(.WIDTH(16), .STEP(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .A(op_a), .B(op_b),
        .signed_mode(sm), .busy(busy), .done(done),
        .GT(gt), .EQ(eq), .LT(lt), .Y(y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden ordering of the w-bit operands as plain integers: {GT,EQ,LT}.
    function automatic logic [2:0] golden(input logic [15:0] a, input logic [15:0] b,
                                          input logic sgn, input int w);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        return {sa > sb, sa == sb, sa < sb};
    endfunction

    // Digits examined = first differing digit + 1 (the sign flip cancels in the XOR).
    function automatic int first_k(input logic [15:0] a, input logic [15:0] b,
                                   input int w, input int s);
        logic [15:0] x;
        x = a ^ b;
        for (int d = 0; d < w / s; d++) begin
            if (((x >> (w - s * (d + 1))) & ((16'd1 << s) - 16'd1)) != 16'd0) return d + 1;
        end
        return w / s;
    endfunction

    // Reference for the 16/4 instance: countdown of k cycles, result published at its end.
    int         m_rem = 0;
    logic [2:0] m_pend = 3'b000;
    logic [2:0] m_res = 3'b000;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            m_rem = 0; m_res = 3'b000; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin m_done = 1'b1; m_res = m_pend; end
            end else if (start) begin
                m_rem  = first_k(op_a, op_b, 16, 4);
                m_pend = golden(op_a, op_b, sm, 16);
            end
            m_busy = (m_rem > 0);
        end
    end

    for (genvar g = 0; g < 9; g++) begin : g_sw
        localparam int W = 4 << (g / 3);
        localparam int S = 1 << (g % 3);
        logic         st, ssm, bsy, dn, sgt, seq, slt, sy, fin;
        logic [W-1:0] sa, sb;
        int           rem = 0;
        logic [2:0]   pend = 3'b000;
        logic [2:0]   res = 3'b000;
        logic         mb = 1'b0;
        logic         md = 1'b0;

        cpt_seq #(.WIDTH(W), .STEP(S)) u_sw (
            .clk(clk), .rst(rst), .start(st), .A(sa), .B(sb),
            .signed_mode(ssm), .busy(bsy), .done(dn),
            .GT(sgt), .EQ(seq), .LT(slt), .Y(sy)
        );

        always @(posedge clk) begin
            if (rst) begin
                rem = 0; res = 3'b000; mb = 1'b0; md = 1'b0;
            end else begin
                md = 1'b0;
                if (rem > 0) begin
                    rem--;
                    if (rem == 0) begin md = 1'b1; res = pend; end
                end else if (st) begin
                    rem  = first_k(16'(sa), 16'(sb), W, S);
                    pend = golden(16'(sa), 16'(sb), ssm, W);
                end
                mb = (rem > 0);
            end
        end

        assign sw_act[g] = {bsy, dn, sgt, seq, slt, sy};
        assign sw_exp[g] = {mb, md, res, res[2]};
        assign sw_fin[g] = fin;

        initial begin
            st = 1'b0; sa = '0; sb = '0; ssm = 1'b0; fin = 1'b0;
            wait (sw_go);
            repeat (800) begin
                @(negedge clk);
                st  = ($urandom_range(0, 2) == 0);
                ssm = 1'($urandom_range(0, 1));
                sa  = W'($urandom);
                case ($urandom_range(0, 3))
                    0:       sb = sa;
                    1:       sb = sa ^ (W'(1) << $urandom_range(0, W - 1));
                    default: sb = W'($urandom);
                endcase
            end
            @(negedge clk);
            st  = 1'b0;
            fin = 1'b1;
        end
    end

    // Per-cycle comparison of every instance against its reference.
    always @(negedge clk) begin
        if (chk_on) begin
            n_total++;
            if ({busy, done, gt, eq, lt, y} !== {m_busy, m_done, m_res, m_res[2]})
                $display("FAIL main_cycle @%0t: got %b expected %b (busy,done,GT,EQ,LT,Y)",
                         $time, {busy, done, gt, eq, lt, y}, {m_busy, m_done, m_res, m_res[2]});
            else
                n_pass++;
        end
        if (sw_on) begin
            for (int g = 0; g < 9; g++) begin
                n_total++;
                if (sw_act[g] !== sw_exp[g])
                    $display("FAIL sweep_cfg%0d_cycle @%0t: got %b expected %b (busy,done,GT,EQ,LT,Y)",
                             g, $time, sw_act[g], sw_exp[g]);
                else
                    n_pass++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else             n_pass++;
    endtask

    // Called at a negedge; issues one compare and waits (bounded) for done.
    // poke > 0 re-asserts start with swapped operands on that cycle of the run.
    task automatic do_cmp(input string name, input logic [15:0] ta, input logic [15:0] tbv,
                          input logic tsm, input logic [2:0] exp_res, input int exp_k,
                          input int poke);
        int cyc;
        int busy_cnt;
        bit got;
        start = 1'b1; op_a = ta; op_b = tbv; sm = tsm;
        cyc = 0; busy_cnt = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = (poke != 0 && cyc == poke);
            if (start) begin op_a = tbv; op_b = ta; end
            if (busy) busy_cnt++;
            if (done) got = 1'b1;
        end
        chk({name, "_latency"}, got ? 32'(cyc - 1) : 32'd99, 32'(exp_k));
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_k));
        chk({name, "_result"}, {28'd0, y, gt, eq, lt}, {28'd0, exp_res[2], exp_res});
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; op_a = 16'h0000; op_b = 16'h0000; sm = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {26'd0, busy, done, gt, eq, lt, y}, 32'd0);
        chk("model_k_1234_1235", 32'(first_k(16'h1234, 16'h1235, 16, 4)), 32'd4);
        chk("model_signed_8000_7fff", {29'd0, golden(16'h8000, 16'h7FFF, 1'b1, 16)}, 32'b001);
        rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);

        do_cmp("u_1234_1235", 16'h1234, 16'h1235, 1'b0, 3'b001, 4, 0);
        do_cmp("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 3'b100, 1, 0);
        do_cmp("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 3'b001, 1, 0);
        do_cmp("u_beef_eq",   16'hBEEF, 16'hBEEF, 1'b0, 3'b010, 4, 0);
        do_cmp("s_beef_eq",   16'hBEEF, 16'hBEEF, 1'b1, 3'b010, 4, 0);
        do_cmp("s_fff0_fff1", 16'hFFF0, 16'hFFF1, 1'b1, 3'b001, 4, 0);
        do_cmp("ignore_start", 16'h1234, 16'h1235, 1'b0, 3'b001, 4, 2);
        do_cmp("b2b_0001_0000", 16'h0001, 16'h0000, 1'b0, 3'b100, 4, 0);

        // Reset during the second RUN cycle must abort and clear everything.
        @(negedge clk);
        start = 1'b1; op_a = 16'h1234; op_b = 16'h1235; sm = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_run_reset", {26'd0, busy, done, gt, eq, lt, y}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        do_cmp("after_reset", 16'h0F00, 16'h0E00, 1'b0, 3'b100, 2, 0);

        sw_on = 1'b1;
        sw_go = 1'b1;
        t = 0;
        while (sw_fin != 9'h1FF && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("sweep_finished", {23'd0, sw_fin}, 32'h1FF);
        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
